// File: rtl/frv_mem_if.sv
// frv_mem_if: req/gnt request phase plus recv/ack response phase for one memory port
interface frv_mem_if #(parameter int XLEN = 32);
  logic req, wen, gnt, recv, ack, error;
  logic [3:0] strb;
  logic [XLEN-1:0] wdata, addr, rdata;
  modport master(output req, wen, strb, wdata, addr, ack, input gnt, recv, error, rdata);
  modport slave(input req, wen, strb, wdata, addr, ack, output gnt, recv, error, rdata);
endinterface

// File: rtl/frv_mem_arbiter.sv
// frv_mem_arbiter: shares one memory port between imem and dmem, routing responses in issue order
module frv_mem_arbiter #(
  parameter int XLEN = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter bit ROUND_ROBIN = 1
)(
  input  logic clock,
  input  logic reset,
  frv_mem_if.slave imem,
  frv_mem_if.slave dmem,
  frv_mem_if.master mem,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic err_spurious
);
  localparam int CW = $clog2(MAX_OUTSTANDING+1);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  typedef enum logic [1:0] {FREE, HOLD_D, HOLD_I} lock_t;
  lock_t lock;
  logic rr_last, sel, sel_req, full, empty, accept, pop, head;
  logic [MAX_OUTSTANDING-1:0] ids;
  logic [PW-1:0] wp, rp;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(MAX_OUTSTANDING-1) ? '0 : p + 1'b1;
  endfunction
  // ID 1 = imem, 0 = dmem; a held lock overrides arbitration until the handshake completes
  always_comb begin
    sel = lock == HOLD_I ? 1'b1 : lock == HOLD_D ? 1'b0 :
          (imem.req && dmem.req) ? (ROUND_ROBIN ? !rr_last : 1'b0) : imem.req;
    sel_req = sel ? imem.req : dmem.req;
    full = outstanding == CW'(MAX_OUTSTANDING);
    empty = outstanding == '0;
    head = ids[rp];
    accept = mem.req && mem.gnt;
    pop = mem.recv && mem.ack;
  end
  assign mem.req = !reset && sel_req && !full;
  assign mem.wen = sel ? imem.wen : dmem.wen;
  assign mem.strb = sel ? imem.strb : dmem.strb;
  assign mem.wdata = sel ? imem.wdata : dmem.wdata;
  assign mem.addr = sel ? imem.addr : dmem.addr;
  assign mem.ack = !reset && !empty && (head ? imem.ack : dmem.ack);
  assign imem.gnt = accept && sel;
  assign dmem.gnt = accept && !sel;
  assign imem.recv = !reset && !empty && head && mem.recv;
  assign dmem.recv = !reset && !empty && !head && mem.recv;
  assign imem.rdata = mem.rdata;
  assign dmem.rdata = mem.rdata;
  assign imem.error = mem.error;
  assign dmem.error = mem.error;
  always_ff @(posedge clock) begin
    if (reset) begin
      lock <= FREE;
      rr_last <= 1'b1;
      ids <= '0;
      wp <= '0;
      rp <= '0;
      outstanding <= '0;
      err_spurious <= 1'b0;
    end else begin
      lock <= (mem.req && !mem.gnt) ? (sel ? HOLD_I : HOLD_D) : FREE;
      if (accept) begin
        ids[wp] <= sel;
        wp <= nxt(wp);
        rr_last <= sel;
      end
      if (pop) rp <= nxt(rp);
      outstanding <= outstanding + CW'(accept) - CW'(pop);
      if (mem.recv && empty) err_spurious <= 1'b1;
    end
  end
endmodule

// File: tb/tb_frv_mem_arbiter.sv
// tb_frv_mem_arbiter: vector table plus scoreboarded sequences for the memory arbiter
module tb_frv_mem_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  frv_mem_if #(.XLEN(32)) ip (), dp (), mp (), ip2 (), dp2 (), mp2 ();
  logic [1:0] out1, out2;
  logic sp1, sp2;
  frv_mem_arbiter #(.XLEN(32), .MAX_OUTSTANDING(2), .ROUND_ROBIN(1)) dut (
    .clock(clock), .reset(reset), .imem(ip), .dmem(dp), .mem(mp), .outstanding(out1), .err_spurious(sp1));
  frv_mem_arbiter #(.XLEN(32), .MAX_OUTSTANDING(2), .ROUND_ROBIN(0)) dut_fp (
    .clock(clock), .reset(reset), .imem(ip2), .dmem(dp2), .mem(mp2), .outstanding(out2), .err_spurious(sp2));
  assign ip2.req = ip.req;
  assign ip2.wen = ip.wen;
  assign ip2.strb = ip.strb;
  assign ip2.wdata = ip.wdata;
  assign ip2.addr = ip.addr;
  assign ip2.ack = ip.ack;
  assign dp2.req = dp.req;
  assign dp2.wen = dp.wen;
  assign dp2.strb = dp.strb;
  assign dp2.wdata = dp.wdata;
  assign dp2.addr = dp.addr;
  assign dp2.ack = dp.ack;
  assign mp2.gnt = mp.gnt;
  assign mp2.recv = mp.recv;
  assign mp2.error = mp.error;
  assign mp2.rdata = mp.rdata;

  typedef struct packed {logic port; logic err; logic [31:0] data;} exp_t;
  // ctl = {rst,ireq,dreq,iwen,dwen,gnt,recv,iack,dack}; x = {req,wen,ignt,dgnt,ack,irecv,drecv}
  typedef struct {logic [8:0] ctl; logic [6:0] x; logic [31:0] xaddr;} vec_t;
  exp_t sb[$];
  vec_t vt[9];
  int n = 0, fails = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic idle();
    ip.req = 1'b0; ip.wen = 1'b0; ip.strb = '0; ip.wdata = '0; ip.addr = '0; ip.ack = 1'b0;
    dp.req = 1'b0; dp.wen = 1'b0; dp.strb = '0; dp.wdata = '0; dp.addr = '0; dp.ack = 1'b0;
    mp.gnt = 1'b0; mp.recv = 1'b0; mp.error = 1'b0; mp.rdata = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1 idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    sb.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic respond();
    mp.recv = 1'b1;
    ip.ack = 1'b1;
    dp.ack = 1'b1;
    if (sb.size() > 0) begin
      mp.rdata = sb[0].data;
      mp.error = sb[0].err;
    end
  endtask

  task automatic check_resp(string nm);
    exp_t e;
    logic [34:0] got, want;
    n++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s: response check with no expected entry", nm);
      return;
    end
    e = sb.pop_front();
    got = {ip.recv, dp.recv, mp.ack, ip.recv ? ip.error : dp.error, ip.recv ? ip.rdata : dp.rdata};
    want = {e.port, !e.port, 1'b1, e.err, e.data};
    if (got !== want) begin
      fails++;
      $display("FAIL %s: {irecv,drecv,ack,err,rdata} got %h required %h", nm, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{9'b000000000, 7'b0000000, 32'h0};
    vt[1] = '{9'b001011000, 7'b1101000, 32'h100};
    vt[2] = '{9'b010001000, 7'b1010000, 32'h40};
    vt[3] = '{9'b011101000, 7'b1001000, 32'h100};
    vt[4] = '{9'b011010000, 7'b1100000, 32'h100};
    vt[5] = '{9'b010100000, 7'b1100000, 32'h40};
    vt[6] = '{9'b000000111, 7'b0000000, 32'h0};
    vt[7] = '{9'b111111111, 7'b0000000, 32'h0};
    vt[8] = '{9'b001000000, 7'b1000000, 32'h100};
    do_reset();
    chk("rst_outstanding", 32'(out1), 32'd0);
    chk("rst_spurious", 32'(sp1), 32'd0);
    for (int i = 0; i < 9; i++) begin
      do_reset();
      {reset, ip.req, dp.req, ip.wen, dp.wen, mp.gnt, mp.recv, ip.ack, dp.ack} = vt[i].ctl;
      ip.addr = 32'h40; dp.addr = 32'h100;
      ip.wdata = 32'hA5A5_0001; dp.wdata = 32'h5A5A_0002;
      ip.strb = 4'h3; dp.strb = 4'hC;
      @(negedge clock);
      chk($sformatf("v%0d_ctl", i),
          32'({mp.req, vt[i].x[6] ? mp.wen : 1'b0, ip.gnt, dp.gnt, mp.ack, ip.recv, dp.recv}), 32'(vt[i].x));
      if (vt[i].x[6]) begin
        chk($sformatf("v%0d_addr", i), mp.addr, vt[i].xaddr);
        chk($sformatf("v%0d_wdata", i), mp.wdata, vt[i].xaddr == 32'h40 ? 32'hA5A5_0001 : 32'h5A5A_0002);
        chk($sformatf("v%0d_strb", i), 32'(mp.strb), vt[i].xaddr == 32'h40 ? 32'h3 : 32'hC);
      end
    end

    do_reset();
    dp.req = 1'b1; dp.addr = 32'h100; mp.gnt = 1'b1;
    @(negedge clock);
    chk("a_dgnt", 32'(dp.gnt), 32'd1);
    chk("a_ignt", 32'(ip.gnt), 32'd0);
    chk("a_addr", mp.addr, 32'h100);
    sb.push_back('{port: 1'b0, err: 1'b0, data: 32'hDEADBEEF});
    tick();
    @(negedge clock);
    chk("a_out1", 32'(out1), 32'd1);
    tick();
    respond();
    @(negedge clock);
    check_resp("a_resp");
    tick();
    @(negedge clock);
    chk("a_out0", 32'(out1), 32'd0);

    do_reset();
    for (int k = 0; k < 5; k++) begin
      ip.req = k < 4; dp.req = k < 4;
      ip.addr = 32'h200; dp.addr = 32'h300; mp.gnt = 1'b1;
      if (k > 0) respond();
      @(negedge clock);
      if (k < 4) begin
        chk($sformatf("rr%0d_ignt", k), 32'(ip.gnt), 32'(k % 2));
        chk($sformatf("rr%0d_dgnt", k), 32'(dp.gnt), 32'(1 - k % 2));
        chk($sformatf("rr%0d_addr", k), mp.addr, k % 2 ? 32'h200 : 32'h300);
        chk($sformatf("fp%0d_gnt", k), 32'({ip2.gnt, dp2.gnt}), 32'b01);
        sb.push_back('{port: 1'(k % 2), err: 1'b0, data: 32'h1000 + 32'(k)});
      end
      if (k > 0) check_resp($sformatf("rr%0d_resp", k));
      tick();
    end

    do_reset();
    for (int k = 0; k < 4; k++) begin
      ip.req = 1'b1; ip.addr = 32'h40;
      dp.req = k > 0; dp.addr = 32'h80;
      mp.gnt = k == 3;
      @(negedge clock);
      chk($sformatf("lk%0d_addr", k), mp.addr, 32'h40);
      chk($sformatf("lk%0d_dgnt", k), 32'(dp.gnt), 32'd0);
      chk($sformatf("lk%0d_ignt", k), 32'(ip.gnt), 32'(k == 3));
      tick();
    end
    sb.push_back('{port: 1'b1, err: 1'b0, data: 32'hAAAA_0040});
    dp.req = 1'b1; dp.addr = 32'h80; mp.gnt = 1'b1;
    respond();
    @(negedge clock);
    chk("lk_after_dgnt", 32'(dp.gnt), 32'd1);
    chk("lk_after_addr", mp.addr, 32'h80);
    check_resp("lk_resp_i");
    sb.push_back('{port: 1'b0, err: 1'b0, data: 32'hBBBB_0080});
    tick();
    respond();
    @(negedge clock);
    check_resp("lk_resp_d");

    do_reset();
    dp.req = 1'b1; dp.addr = 32'h500; mp.gnt = 1'b1;
    @(negedge clock);
    chk("f_gnt1", 32'(dp.gnt), 32'd1);
    sb.push_back('{port: 1'b0, err: 1'b0, data: 32'h11});
    tick();
    ip.req = 1'b1; ip.addr = 32'h600; mp.gnt = 1'b1;
    @(negedge clock);
    chk("f_gnt2", 32'(ip.gnt), 32'd1);
    sb.push_back('{port: 1'b1, err: 1'b1, data: 32'h22});
    tick();
    dp.req = 1'b1; dp.addr = 32'h700; mp.gnt = 1'b1;
    @(negedge clock);
    chk("f_out_full", 32'(out1), 32'd2);
    chk("f_full_req", 32'({mp.req, dp.gnt, ip.gnt}), 32'd0);
    tick();
    dp.req = 1'b1; dp.addr = 32'h700; mp.gnt = 1'b1;
    respond();
    @(negedge clock);
    chk("f_nobypass", 32'({mp.req, dp.gnt}), 32'd0);
    check_resp("f_pop");
    tick();
    dp.req = 1'b1; dp.addr = 32'h700; mp.gnt = 1'b1;
    @(negedge clock);
    chk("f_reaccept", 32'({mp.req, dp.gnt}), 32'b11);
    chk("f_reaccept_addr", mp.addr, 32'h700);
    sb.push_back('{port: 1'b0, err: 1'b0, data: 32'h33});
    tick();
    @(negedge clock);
    chk("f_out_refull", 32'(out1), 32'd2);
    tick();
    respond();
    @(negedge clock);
    check_resp("e_err1_imem");
    tick();
    respond();
    @(negedge clock);
    check_resp("e_err0_dmem");
    tick();
    @(negedge clock);
    chk("e_out0", 32'(out1), 32'd0);

    do_reset();
    mp.recv = 1'b1; mp.rdata = 32'h99; ip.ack = 1'b1; dp.ack = 1'b1;
    @(negedge clock);
    chk("s_noack", 32'({mp.ack, ip.recv, dp.recv}), 32'd0);
    tick();
    @(negedge clock);
    chk("s_flag", 32'(sp1), 32'd1);
    repeat (3) tick();
    @(negedge clock);
    chk("s_sticky", 32'(sp1), 32'd1);
    do_reset();
    chk("s_cleared", 32'(sp1), 32'd0);
    dp.req = 1'b1; dp.addr = 32'h900; mp.gnt = 1'b1;
    tick();
    do_reset();
    chk("m_out0", 32'(out1), 32'd0);
    mp.recv = 1'b1; dp.ack = 1'b1;
    @(negedge clock);
    chk("m_late_recv", 32'({mp.ack, dp.recv}), 32'd0);
    tick();
    @(negedge clock);
    chk("m_late_flag", 32'(sp1), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule

// File: doc/frv_mem_arbiter.md
Name: frv_mem_arbiter

Overview:
- Shares one downstream memory port between the core's instruction (imem) and data (dmem) request ports.
- Uses the req/gnt request phase and recv/ack response phase throughout.
- Tracks outstanding accepted requests in an in-order ID FIFO, so each response is routed back to the port that issued it.
- Sits between frv_core and a single-ported memory or bus bridge, in both simulation and formal environments.

Parameters:
- XLEN, 32, data and address width.
- MAX_OUTSTANDING, 2, depth of the outstanding-ID FIFO (≥1).
- ROUND_ROBIN, 1, 1 = alternate on contention; 0 = fixed priority, dmem wins.

Ports:
- clock  in  1  global clock
- reset  in  1  synchronous, active-high reset
- imem_req / dmem_req  in  1  port request
- imem_wen / dmem_wen  in  1  write enable
- imem_strb / dmem_strb  in  4  write strobe
- imem_wdata / dmem_wdata  in  XLEN  write data
- imem_addr / dmem_addr  in  XLEN  address
- imem_gnt / dmem_gnt  out  1  request accepted
- imem_recv / dmem_recv  out  1  response valid to port
- imem_ack / dmem_ack  in  1  port accepts response
- imem_error / dmem_error  out  1  response error (broadcast)
- imem_rdata / dmem_rdata  out  XLEN  read data (broadcast)
- mem_req  out  1  downstream request
- mem_wen  out  1  downstream write enable
- mem_strb  out  4  downstream strobe
- mem_wdata  out  XLEN  downstream write data
- mem_addr  out  XLEN  downstream address
- mem_gnt  in  1  downstream accepts request
- mem_recv  in  1  downstream response valid
- mem_ack  out  1  response consumed
- mem_error  in  1  downstream error
- mem_rdata  in  XLEN  downstream read data
- outstanding  out  clog2(MAX_OUTSTANDING+1)  accepted-but-unanswered count
- err_spurious  out  1  sticky flag: mem_recv seen with FIFO empty

Behaviour:
- Reset: FIFO empty, outstanding=0, lock cleared, RR pointer favours dmem, err_spurious=0.
  - While reset is high, mem_req, mem_ack, all gnt and all recv are forced to 0.
- Request phase:
  - sel = locked owner if lock set; otherwise the arbitration winner among requesting ports.
  - mem_req = sel_req && !fifo_full. mem_wen, strb, wdata and addr are muxed from sel (combinational, zero latency).
  - sel_gnt = mem_gnt && mem_req. The non-selected gnt is 0.
- Lock:
  - Set when mem_req=1 and mem_gnt=0; holds sel stable until the handshake completes.
  - Cleared on mem_req && mem_gnt.
  - If the locked requester drops req (protocol violation), lock clears the next cycle.
- Arbitration:
  - Single requester wins.
  - Both requesting, ROUND_ROBIN=1: the port not granted most recently wins. The RR pointer updates only on an accepted handshake.
  - Both requesting, ROUND_ROBIN=0: dmem wins.
- Accept (mem_req && mem_gnt): push sel ID (0=dmem, 1=imem) into FIFO.
- Full (outstanding==MAX_OUTSTANDING): mem_req=0, both gnt=0. Requests wait.
- Response phase:
  - head = FIFO head ID. Only head's recv = mem_recv. mem_ack = head's ack.
  - rdata/error pass through to both ports unregistered.
  - Pop on mem_recv && mem_ack.
- Simultaneous push and pop in one cycle: outstanding unchanged, ordering preserved. This applies when full too: a pop frees no slot for the same-cycle request, so mem_req stays 0 that cycle (no full→pop bypass).
- Empty FIFO with mem_recv=1: mem_ack=0, both recv=0, err_spurious set (cleared only by reset).
- FIFO pointers wrap modulo MAX_OUTSTANDING.
- outstanding is registered and updates the cycle after push/pop.
- Reset mid-transaction: all state discarded. Late responses from the downstream after reset flag err_spurious.

Test Plan:
- Reset then dmem_req at addr 0x100, mem_gnt=1 same cycle → dmem_gnt=1, mem_addr=0x100, outstanding=1 next cycle; mem_recv=1, rdata=0xDEADBEEF, dmem_ack=1 → dmem_recv=1, dmem_rdata=0xDEADBEEF, outstanding=0.
- Both ports request continuously, mem_gnt=1 always, ROUND_ROBIN=1, responses returned every cycle → grants alternate D,I,D,I. With ROUND_ROBIN=0 → all four grants go to dmem.
- imem request at 0x40 with mem_gnt held 0 for 3 cycles while dmem_req rises → mem_addr stays 0x40 and imem keeps ownership; dmem_gnt=0 until the imem handshake completes.
- MAX_OUTSTANDING=2: two accepts with no responses → third request sees mem_req=0. Then in one cycle, pop one response (mem_recv=1, mem_ack=1) while the third request is held → mem_req still 0 that cycle (no full→pop bypass). Next cycle mem_req=1, accepted, outstanding=2.
- Issue imem then dmem; return two responses with mem_error=1 then 0 → imem_recv sees error=1 first, then dmem_recv sees error=0. Ordering matches issue.
- mem_recv=1 with nothing outstanding → mem_ack=0, no port recv, err_spurious=1 and stays 1 until reset.
